// File: rtl/pc_npc_sequencer.sv
// Fetch-side PC/nPC sequencer with one-delay-slot branch redirect and stall-time redirect buffering.
// Optional taken-redirect counter is enabled by defining BRANCH_COUNT_EN.
module pc_npc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        fetch_valid,
    output logic        in_delay_slot,
    output logic        pending_redirect
`ifdef BRANCH_COUNT_EN
    ,
    output logic [31:0] taken_count
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, HOLD_PEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_q, pend_d;
    logic        ds_q, ds_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        adv;
    logic        applied;
    logic [31:0] live_target;
    logic        unused_tgt_bits;

    assign live_target     = {redirect_target[31:2], 2'b00};
    assign unused_tgt_bits = ^redirect_target[1:0];
    assign adv             = (state_q != BOOT) && !stall && fetch_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        npc_d         = npc_q;
        pend_target_d = pend_target_q;
        pend_d        = pend_q;
        ds_d          = ds_q;
        applied       = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, HOLD: begin
                if (adv) begin
                    pc_d    = npc_q;
                    npc_d   = redirect ? live_target : npc_q + PC_STEP;
                    ds_d    = redirect;
                    applied = redirect;
                    state_d = RUN;
                end else if (redirect) begin
                    pend_target_d = live_target;
                    pend_d        = 1'b1;
                    state_d       = HOLD_PEND;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD_PEND: begin
                // Buffered redirect beats any live one arriving on the resume cycle.
                if (adv) begin
                    pc_d    = npc_q;
                    npc_d   = pend_target_q;
                    ds_d    = 1'b1;
                    pend_d  = 1'b0;
                    applied = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        fetch_valid_d = (state_d != BOOT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC + 32'd4;
            pend_target_q <= 32'h0;
            pend_q        <= 1'b0;
            ds_q          <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            pend_target_q <= pend_target_d;
            pend_q        <= pend_d;
            ds_q          <= ds_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign pc               = pc_q;
    assign npc              = npc_q;
    assign fetch_valid      = fetch_valid_q;
    assign in_delay_slot    = ds_q;
    assign pending_redirect = pend_q;

`ifdef BRANCH_COUNT_EN
    logic [31:0] taken_q, taken_d;

    always_comb begin
        taken_d = taken_q;
        if (applied) taken_d = taken_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) taken_q <= 32'h0;
        else       taken_q <= taken_d;
    end

    assign taken_count = taken_q;
`else
    logic unused_applied;
    assign unused_applied = applied;
`endif

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Directed bench for pc_npc_sequencer; checks taken_count too when BRANCH_COUNT_EN is defined.
module tb_pc_npc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, fetch_ready;
    logic [31:0] redirect_target;
    logic [31:0] pc, npc;
    logic        fetch_valid, in_delay_slot, pending_redirect;
`ifdef BRANCH_COUNT_EN
    logic [31:0] taken_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_npc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .fetch_ready      (fetch_ready),
        .pc               (pc),
        .npc              (npc),
        .fetch_valid      (fetch_valid),
        .in_delay_slot    (in_delay_slot),
        .pending_redirect (pending_redirect)
`ifdef BRANCH_COUNT_EN
        ,
        .taken_count      (taken_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {pc, npc, fetch_valid, in_delay_slot, pending_redirect} after the last edge.
    task automatic expect_state(input string name, input logic [31:0] e_pc, input logic [31:0] e_npc,
                                input logic e_fv, input logic e_ds, input logic e_pend);
        checks++;
        if ({pc, npc, fetch_valid, in_delay_slot, pending_redirect} !== {e_pc, e_npc, e_fv, e_ds, e_pend}) begin
            errors++;
            $display("FAIL %s: pc=%h npc=%h fv=%b ds=%b pend=%b, required pc=%h npc=%h fv=%b ds=%b pend=%b",
                     name, pc, npc, fetch_valid, in_delay_slot, pending_redirect, e_pc, e_npc, e_fv, e_ds, e_pend);
        end
    endtask

    task automatic expect_taken(input string name, input logic [31:0] e_cnt);
`ifdef BRANCH_COUNT_EN
        checks++;
        if (taken_count !== e_cnt) begin
            errors++;
            $display("FAIL %s: taken_count=%0d, required %0d", name, taken_count, e_cnt);
        end
`else
        if (e_cnt === 32'hx) $display("unexpected count %s", name);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; fetch_ready = 1'b1;
        step(); step();
        expect_state("reset", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
        expect_taken("reset_count", 32'd0);
    endtask

    task automatic test_free_run();
        reset = 1'b0;
        step();
        expect_state("boot_exit", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("run_4", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("run_8", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_target = 32'h100;
        step();
        expect_state("redir_slot", 32'hC, 32'h100, 1'b1, 1'b1, 1'b0);
        expect_taken("redir_count", 32'd1);
        redirect = 1'b0;
        step();
        expect_state("redir_target", 32'h100, 32'h104, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall_pending();
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h200;
        step();
        expect_state("stall_latch", 32'h100, 32'h104, 1'b1, 1'b0, 1'b1);
        redirect = 1'b0;
        step(); step();
        expect_state("stall_hold", 32'h100, 32'h104, 1'b1, 1'b0, 1'b1);
        stall = 1'b0;
        step();
        expect_state("stall_release", 32'h104, 32'h200, 1'b1, 1'b1, 1'b0);
        expect_taken("stall_count", 32'd2);
        step();
        expect_state("stall_after", 32'h200, 32'h204, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_first_wins();
        fetch_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h200;
        step();
        redirect_target = 32'h300;
        step();
        expect_state("first_hold", 32'h200, 32'h204, 1'b1, 1'b0, 1'b1);
        fetch_ready = 1'b1; redirect_target = 32'h400;
        step();
        expect_state("first_release", 32'h204, 32'h200, 1'b1, 1'b1, 1'b0);
        expect_taken("first_count", 32'd3);
        redirect = 1'b0;
    endtask

    task automatic test_misaligned_wrap();
        redirect = 1'b1; redirect_target = 32'h103;
        step();
        expect_state("misaligned", 32'h200, 32'h100, 1'b1, 1'b1, 1'b0);
        redirect_target = 32'hFFFF_FFFC;
        step();
        expect_state("back_to_back", 32'h100, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        redirect = 1'b0;
        step();
        expect_state("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_taken("wrap_count", 32'd5);
        step();
        expect_state("wrap_next", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall_and_not_ready();
        stall = 1'b1; fetch_ready = 1'b0;
        step();
        expect_state("double_hold", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
        stall = 1'b0; fetch_ready = 1'b1;
        step();
        expect_state("double_release", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_pend();
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h500;
        step();
        expect_state("pend_before_rst", 32'h4, 32'h8, 1'b1, 1'b0, 1'b1);
        reset = 1'b1; redirect = 1'b0;
        step();
        expect_state("rst_in_pend", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
        expect_taken("rst_count", 32'd0);
        reset = 1'b0; stall = 1'b0;
        step();
        expect_state("rst_boot_exit", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("rst_run", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_redirect();
        test_stall_pending();
        test_first_wins();
        test_misaligned_wrap();
        test_stall_and_not_ready();
        test_reset_in_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
